uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single transmit side of one `uart` instance (`wr_uart` / `w_data` / `tx_full`) among 4 byte-wide requesters.
- Requesters are, for example, the IO memory dump path, an echo path and a debug path.
- Arbitration is round-robin, one byte per grant.
- Writes into the UART TX FIFO are issued only when `tx_full` is low, as a single-cycle `wr_uart` pulse.

Parameters:
- N_REQ, 4, number of requesters (fixed at 4 in this revision; `req` / `ack` / `gnt` widths follow it).
- MAX_BURST, 4, maximum bytes per grant when UART_ARB_BURST_EN is defined (1..15).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-requester byte request; held with `din` stable until `ack`.
- lock  input  4  per-requester burst hold; used only with UART_ARB_BURST_EN.
- din  input  32  packed request bytes; `din[8i+7:8i]` belongs to requester i.
- tx_full  input  1  UART TX FIFO full flag.
- ack  output  4  one-cycle pulse; byte from requester i accepted.
- gnt  output  4  one-hot current grant; 0 when idle.
- wr_uart  output  1  one-cycle write strobe to the UART.
- w_data  output  8  byte to the UART; valid when `wr_uart` is 1.
- busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (`rst` sampled high at a `clk` edge):
  - state=IDLE; `ack`, `gnt`, `wr_uart`, `busy` = 0; `w_data` = 8'h00.
  - Round-robin pointer `last` = 3, so requester 0 has top priority first.
  - Burst counter = 0.
  - Reset mid-operation abandons the transfer: no `wr_uart` and no `ack` in the reset cycle or after it.
- All outputs are registered.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If `req` != 0, select the first set bit scanning `last+1, last+2, ...` modulo 4.
  - Register `gnt` one-hot, set `busy`, go to GRANT.
  - If `req` == 0, stay in IDLE.
- GRANT, request dropped: if the granted `req` bit is 0 (protocol violation), clear `gnt` and go to IDLE. No write, no ack, `last` unchanged.
- GRANT, `tx_full` = 1: stay in GRANT, `wr_uart` = 0. The grant is held indefinitely; there is no timeout.
- GRANT, `tx_full` = 0: in the next cycle assert `wr_uart` = 1, `w_data` = the granted `din` byte, and the granted `ack` bit = 1, all for exactly one cycle.
  - Set `last` = granted index.
  - Go to GAP.
- GAP: one dead cycle, so the requester can drop `req` and the UART `tx_full` can update.
  - Clear `gnt`; go to IDLE.
  - Burst exception: see Optional Feature.
- Latency:
  - `req` rising in IDLE with `tx_full` = 0: `gnt` on edge +1, `wr_uart` / `ack` on edge +2.
  - One byte per requester-grant uses 3 cycles, so maximum throughput is 1 byte every 3 clocks.
- Simultaneous requests: resolved strictly round-robin. After granting i, requester i has the lowest priority next round.
- Requests arriving during GRANT or GAP are not considered until the next IDLE.
- `tx_full` rising in the same cycle a write is decided is not rechecked. The UART FIFO never overflows because the FIFO updates `tx_full` within 1 cycle and GAP guarantees spacing.
- Invariants:
  - `gnt` is always 0 or one-hot.
  - `ack` == `gnt` AND `wr_uart`, replicated per bit.

Optional Feature:
- Macro: UART_ARB_BURST_EN.
- Defined:
  - In GAP, if the granted requester has `lock` = 1, `req` = 1 and burst count < MAX_BURST-1, increment the count and return to GRANT with `gnt` held. `busy` stays 1.
  - The burst ends when `lock` drops, `req` drops, or the count limit is reached. Then go to IDLE and clear the count.
  - `last` updates on every accepted byte; there is no side effect within a burst.
- Not defined: the `lock` input is ignored (may be left unconnected or tied 0); every grant carries exactly one byte.

Test Plan:
- Reset then `req`=4'b0001, `din[7:0]`=8'h41, `tx_full`=0:
  - `gnt`=0001 at edge 1.
  - `wr_uart`=1, `w_data`=8'h41, `ack`=0001 at edge 2, each for one cycle.
  - `busy` low again by edge 4.
- `req`=4'b1111 held continuously, bytes 8'h10/8'h20/8'h30/8'h40 on ports 0-3:
  - UART receives 10,20,30,40,10,... in that order.
  - Writes are exactly 3 cycles apart.
- `req`=4'b0100, `tx_full`=1 for 10 cycles, then 0:
  - `gnt`=0100 is held and `wr_uart` stays 0 throughout.
  - A single write of the port-2 byte follows 1 cycle after `tx_full` falls.
- Requester 1 granted and stalled by `tx_full`=1, then `req[1]` dropped: state returns to IDLE, no `ack`, no `wr_uart`. Next winner from `req`=0011 is port 0.
- Assert `rst` for 1 cycle while in GRANT with `tx_full`=0: no `wr_uart` or `ack` pulse. All outputs are 0 next cycle; the following grant goes to port 0.
- With UART_ARB_BURST_EN, MAX_BURST=4, port 3 `lock`=1, `req`=1, port 0 also requesting:
  - Port 3 gets 4 consecutive writes.
  - Then `gnt` goes to port 0.
  - Without the macro, grants alternate 3,0,3,0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit port among N_REQ byte requesters.
// Optional multi-byte bursts per grant are enabled by defining UART_ARB_BURST_EN.
module uart_tx_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     lock,
   input  logic [8*N_REQ-1:0]   din,
   input  logic                 tx_full,
   output logic [N_REQ-1:0]     ack,
   output logic [N_REQ-1:0]     gnt,
   output logic                 wr_uart,
   output logic [7:0]           w_data,
   output logic                 busy
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  last;
   logic [IDX_W-1:0]  idx;

   logic              pick_vld_c;
   logic [IDX_W-1:0]  pick_idx_c;
   logic [7:0]        byte_c;

`ifdef UART_ARB_BURST_EN
   logic [CNT_W-1:0]  burst_cnt;
   logic              burst_more_c;
`else
   logic              unused_lock;
   assign unused_lock = ^lock;
`endif

   // Round-robin pick: scan last+1 .. last+N_REQ, nearest set bit wins.
   always_comb begin
      pick_vld_c = 1'b0;
      pick_idx_c = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[IDX_W'((int'(last) + k) % int'(N_REQ))]) begin
            pick_vld_c = 1'b1;
            pick_idx_c = IDX_W'((int'(last) + k) % int'(N_REQ));
         end
      end
   end

   // Byte lane of the currently granted requester.
   always_comb begin
      byte_c = 8'h00;
      for (int i = 0; i < int'(N_REQ); i++) begin
         if (idx == IDX_W'(i)) begin
            byte_c = din[8*i +: 8];
         end
      end
   end

`ifdef UART_ARB_BURST_EN
   always_comb begin
      burst_more_c = lock[idx] && req[idx] &&
                     (burst_cnt < CNT_W'(MAX_BURST - 1));
   end
`endif

   // Arbitration FSM; every output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         gnt     <= '0;
         ack     <= '0;
         wr_uart <= 1'b0;
         w_data  <= 8'h00;
         busy    <= 1'b0;
         last    <= IDX_W'(N_REQ - 1);
         idx     <= '0;
`ifdef UART_ARB_BURST_EN
         burst_cnt <= '0;
`endif
      end else begin
         ack     <= '0;
         wr_uart <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld_c) begin
                  idx   <= pick_idx_c;
                  gnt   <= N_REQ'(1) << pick_idx_c;
                  busy  <= 1'b1;
                  state <= GRANT;
               end
            end

            GRANT: begin
               if (!req[idx]) begin
                  // Requester withdrew while waiting: abandon without a write.
                  gnt   <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
`ifdef UART_ARB_BURST_EN
                  burst_cnt <= '0;
`endif
               end else if (!tx_full) begin
                  wr_uart <= 1'b1;
                  w_data  <= byte_c;
                  ack     <= gnt;
                  last    <= idx;
                  state   <= GAP;
               end
            end

            GAP: begin
`ifdef UART_ARB_BURST_EN
               if (burst_more_c) begin
                  burst_cnt <= burst_cnt + CNT_W'(1);
                  state     <= GRANT;
               end else begin
                  burst_cnt <= '0;
                  gnt       <= '0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
`else
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
`endif
            end

            default: begin
               gnt   <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (default build and UART_ARB_BURST_EN build).
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  lock;
   logic [31:0] din;
   logic        tx_full;
   logic [3:0]  ack;
   logic [3:0]  gnt;
   logic        wr_uart;
   logic [7:0]  w_data;
   logic        busy;

   int n_chk  = 0;
   int n_fail = 0;

   uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .lock    (lock),
      .din     (din),
      .tx_full (tx_full),
      .ack     (ack),
      .gnt     (gnt),
      .wr_uart (wr_uart),
      .w_data  (w_data),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int wr_cnt;
      int last_t;
      logic [3:0] exp_gnt [5];
      logic [7:0] exp_seq [4];

      rst = 1'b1; req = 4'b0000; lock = 4'b0000; din = 32'h0; tx_full = 1'b0;
      tick(); tick();
      chk("rst_gnt",    32'(gnt),     32'h0);
      chk("rst_ack",    32'(ack),     32'h0);
      chk("rst_wr",     32'(wr_uart), 32'h0);
      chk("rst_busy",   32'(busy),    32'h0);
      chk("rst_wdata",  32'(w_data),  32'h0);
      rst = 1'b0;

      // Single byte from port 0
      req = 4'b0001; din[7:0] = 8'h41;
      tick();
      chk("t1_gnt_e1",  32'(gnt),     32'h1);
      chk("t1_wr_e1",   32'(wr_uart), 32'h0);
      chk("t1_busy_e1", 32'(busy),    32'h1);
      tick();
      chk("t1_wr_e2",   32'(wr_uart), 32'h1);
      chk("t1_data_e2", 32'(w_data),  32'h41);
      chk("t1_ack_e2",  32'(ack),     32'h1);
      req = 4'b0000;
      tick();
      chk("t1_wr_e3",   32'(wr_uart), 32'h0);
      chk("t1_ack_e3",  32'(ack),     32'h0);
      chk("t1_gnt_e3",  32'(gnt),     32'h0);
      tick();
      chk("t1_busy_e4", 32'(busy),    32'h0);

      // All four requesting continuously after a fresh reset
      rst = 1'b1; tick(); rst = 1'b0;
      exp_seq[0] = 8'h10; exp_seq[1] = 8'h20; exp_seq[2] = 8'h30; exp_seq[3] = 8'h40;
      req = 4'b1111; din = 32'h4030_2010;
      wr_cnt = 0; last_t = -1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         chk("t2_onehot", 32'($onehot0(gnt)), 32'h1);
         if (wr_uart) begin
            chk("t2_data",    32'(w_data), 32'(exp_seq[wr_cnt % 4]));
            chk("t2_ack_gnt", 32'(ack),    32'(gnt));
            if (wr_cnt == 0) chk("t2_first_edge", 32'(c), 32'd2);
            else             chk("t2_spacing",    32'(c - last_t), 32'd3);
            last_t = c;
            wr_cnt++;
         end
      end
      chk("t2_wr_count", 32'(wr_cnt), 32'd4);
      req = 4'b0000;
      tick(); tick();

      // tx_full stall on port 2
      req = 4'b0100; din[23:16] = 8'h5A; tx_full = 1'b1;
      tick();
      chk("t3_gnt", 32'(gnt), 32'h4);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("t3_hold_gnt", 32'(gnt),     32'h4);
         chk("t3_hold_wr",  32'(wr_uart), 32'h0);
      end
      tx_full = 1'b0;
      tick();
      chk("t3_wr",   32'(wr_uart), 32'h1);
      chk("t3_data", 32'(w_data),  32'h5A);
      chk("t3_ack",  32'(ack),     32'h4);
      req = 4'b0000;
      tick();
      chk("t3_single_wr", 32'(wr_uart), 32'h0);
      tick();

      // Port 1 stalled, then withdraws; last stays at 2 so port 0 wins next
      tx_full = 1'b1; req = 4'b0010;
      tick();
      chk("t4_gnt", 32'(gnt), 32'h2);
      tick();
      req = 4'b0000;
      tick();
      chk("t4_drop_gnt",  32'(gnt),     32'h0);
      chk("t4_drop_ack",  32'(ack),     32'h0);
      chk("t4_drop_wr",   32'(wr_uart), 32'h0);
      chk("t4_drop_busy", 32'(busy),    32'h0);
      req = 4'b0011; din[7:0] = 8'h61; din[15:8] = 8'h62;
      tick();
      chk("t4_next_gnt", 32'(gnt), 32'h1);
      tx_full = 1'b0;
      tick();
      chk("t4_wr_data", 32'(w_data), 32'h61);
      chk("t4_ack",     32'(ack),    32'h1);
      req = 4'b0000;
      tick(); tick();

      // Reset while in GRANT with tx_full low
      req = 4'b0010;
      tick();
      chk("t5_gnt", 32'(gnt), 32'h2);
      rst = 1'b1;
      tick();
      chk("t5_wr",    32'(wr_uart), 32'h0);
      chk("t5_ack",   32'(ack),     32'h0);
      chk("t5_gnt0",  32'(gnt),     32'h0);
      chk("t5_busy",  32'(busy),    32'h0);
      chk("t5_wdata", 32'(w_data),  32'h0);
      rst = 1'b0; req = 4'b0011;
      tick();
      chk("t5_next_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      tick(); tick(); tick();

      // Move last to 2, then port 3 (locked) against port 0
      req = 4'b0100;
      tick(); tick();
      req = 4'b0000;
      tick(); tick();
`ifdef UART_ARB_BURST_EN
      exp_gnt[0] = 4'h8; exp_gnt[1] = 4'h8; exp_gnt[2] = 4'h8; exp_gnt[3] = 4'h8; exp_gnt[4] = 4'h1;
`else
      exp_gnt[0] = 4'h8; exp_gnt[1] = 4'h1; exp_gnt[2] = 4'h8; exp_gnt[3] = 4'h1; exp_gnt[4] = 4'h8;
`endif
      req = 4'b1001; lock = 4'b1000; din[31:24] = 8'hC3; din[7:0] = 8'hA0;
      wr_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk("t6_onehot", 32'($onehot0(gnt)), 32'h1);
         if (wr_uart && wr_cnt < 5) begin
            chk("t6_ack_order", 32'(ack), 32'(exp_gnt[wr_cnt]));
            chk("t6_data", 32'(w_data), (exp_gnt[wr_cnt] == 4'h8) ? 32'hC3 : 32'hA0);
            wr_cnt++;
         end
      end
      chk("t6_wr_count", 32'(wr_cnt), 32'd5);
      req = 4'b0000; lock = 4'b0000;
      tick(); tick();
      chk("t6_idle_busy", 32'(busy), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
